fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with request credits, PC tag FIFO and instruction buffer
//
// Issues word-aligned fetch requests from the fetch PC, tags each accepted
// request with its address, and buffers in-order responses for decode.
// Redirects flush the buffer and drop responses still owed to old requests.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   redirect_valid_i/pc_i flush and restart fetch at redirect_pc_i (low bits cleared)
//   imem_req_*            request channel: valid/ready handshake, addr = fetch PC
//   imem_rsp_*            response channel: in request order, always accepted
//   inst_*, pc_o          decode channel: head of the instruction buffer
//   fetch_err_o           head instruction carries an access fault
module fetch_unit #(
    parameter int              Xlen    = 64,
    parameter int              Ilen    = 32,
    parameter logic [Xlen-1:0] ResetPc = Xlen'(64'h8000_0000),
    parameter int              Depth   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [Xlen-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [Xlen-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [Ilen-1:0] imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [Ilen-1:0] inst_o,
    output logic [Xlen-1:0] pc_o,
    output logic            fetch_err_o
);

    localparam int CW = $clog2(Depth + 1);
    localparam int IW = (Depth > 1) ? $clog2(Depth) : 1;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        if (p == IW'(Depth - 1)) return '0;
        return p + 1'b1;
    endfunction

    logic [Xlen-1:0] fpc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   occ;
    logic [CW-1:0]   drop;
    logic [CW:0]     credit_used;

    // PC tag FIFO: addresses of live requests whose responses are still owed
    logic [Xlen-1:0] tag_mem [Depth];
    logic [IW-1:0]   tag_rd;
    logic [IW-1:0]   tag_wr;

    // Instruction buffer
    logic [Ilen-1:0] buf_data [Depth];
    logic            buf_err  [Depth];
    logic [Xlen-1:0] buf_pc   [Depth];
    logic [IW-1:0]   buf_head;
    logic [IW-1:0]   buf_tail;

    logic req_fire;
    logic rsp_push;
    logic inst_pop;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Every outstanding request already owns a buffer slot, so a response
    // can always be written without back-pressure.
    assign credit_used      = {1'b0, inflight} + {1'b0, occ};
    assign imem_req_valid_o = !rst_i && !redirect_valid_i && (credit_used < (CW + 1)'(Depth));
    assign imem_req_addr_o  = fpc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // Responses in the redirect cycle or owed to pre-redirect requests are dropped.
    assign rsp_push = imem_rsp_valid_i && !rst_i && !redirect_valid_i && (drop == '0);
    // Flush wins over a decode pop in the same cycle.
    assign inst_pop = inst_valid_o && inst_ready_i && !redirect_valid_i;

    assign inst_valid_o = (occ != '0);
    assign inst_o       = buf_data[buf_head];
    assign pc_o         = buf_pc[buf_head];
    assign fetch_err_o  = inst_valid_o && buf_err[buf_head];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpc      <= ResetPc;
            inflight <= '0;
            occ      <= '0;
            drop     <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid_i);
            if (redirect_valid_i) begin
                fpc      <= {redirect_pc_i[Xlen-1:2], 2'b00};
                occ      <= '0;
                // Everything still in flight after this cycle is stale.
                drop     <= inflight - CW'(imem_rsp_valid_i);
                tag_rd   <= '0;
                tag_wr   <= '0;
                buf_head <= '0;
                buf_tail <= '0;
            end else begin
                if (req_fire) begin
                    fpc    <= fpc + Xlen'(4);
                    tag_wr <= ptr_inc(tag_wr);
                end
                if (imem_rsp_valid_i && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (rsp_push) begin
                    tag_rd   <= ptr_inc(tag_rd);
                    buf_tail <= ptr_inc(buf_tail);
                end
                if (inst_pop) begin
                    buf_head <= ptr_inc(buf_head);
                end
                occ <= occ + CW'(rsp_push) - CW'(inst_pop);
            end
        end
    end

    // Storage arrays need no reset; pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            tag_mem[tag_wr] <= fpc;
        end
        if (rsp_push) begin
            buf_data[buf_tail] <= imem_rsp_data_i;
            buf_err[buf_tail]  <= imem_rsp_err_i;
            buf_pc[buf_tail]   <= tag_mem[tag_rd];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

    localparam int          XLEN     = 64;
    localparam int          ILEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic            clk;
    logic            rst_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [ILEN-1:0] imem_rsp_data_i;
    logic            imem_rsp_err_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [ILEN-1:0] inst_o;
    logic [XLEN-1:0] pc_o;
    logic            fetch_err_o;

    fetch_unit #(
        .Xlen   (XLEN),
        .Ilen   (ILEN),
        .ResetPc(RESET_PC),
        .Depth  (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o (imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .imem_rsp_err_i  (imem_rsp_err_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .fetch_err_o     (fetch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          ep;
    } pend_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    pend_t       pending[$];   // memory model: accepted requests awaiting a response
    exp_t        sb[$];        // instructions decode should receive, in program order
    logic [63:0] model_pc;
    int          buffered;     // responses accepted into the buffer and not yet consumed
    int          epoch;
    int          rsp_ep;
    int          n_pass;
    int          n_total;
    int          n_pops;
    bit          started;
    bit          rst_prev;
    bit          hold_armed;
    logic [31:0] hold_inst;
    logic [63:0] hold_pc;
    logic        hold_err;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf ^ {a[63:48], 16'h0};
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        return (a[6:2] == 5'd2) || (a[6:2] == 5'd13);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus; probabilities are per mille.
    task automatic cycle(input int p_ready, input int p_rsp, input int p_iready,
                         input int p_redir, input int p_rst,
                         input logic [63:0] rpc = 64'h0, input bit use_rpc = 1'b0);
        pend_t e;
        @(negedge clk);
        rst_i            = ($urandom_range(999) < p_rst);
        redirect_valid_i = !rst_i && ($urandom_range(999) < p_redir);
        if (use_rpc) redirect_pc_i = rpc;
        else if ($urandom_range(9) == 0) redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        else redirect_pc_i = RESET_PC + 64'($urandom_range(4095));
        imem_req_ready_i = ($urandom_range(999) < p_ready);
        inst_ready_i     = ($urandom_range(999) < p_iready);
        if (rst_i) begin
            pending.delete();
            imem_rsp_valid_i = 1'b0;
        end else if (pending.size() > 0 && ($urandom_range(999) < p_rsp)) begin
            e = pending.pop_front();
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_data(e.addr);
            imem_rsp_err_i   = mem_err(e.addr);
            rsp_ep           = e.ep;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = 32'($urandom);
            imem_rsp_err_i   = 1'($urandom_range(1));
        end
    endtask

    // Request-side monitor and reference model update.
    initial forever begin
        @(negedge clk);
        #1;
        if (started) begin
            chk("req_valid", 64'(imem_req_valid_o),
                64'(!rst_i && !redirect_valid_i &&
                    (pending.size() + (imem_rsp_valid_i ? 1 : 0) + buffered < DEPTH)));
            chk("inst_valid", 64'(inst_valid_o), 64'(buffered != 0));
            if (imem_req_valid_o && imem_req_ready_i) begin
                chk("req_addr", imem_req_addr_o, model_pc);
                pending.push_back('{addr: model_pc, ep: epoch});
                sb.push_back('{pc: model_pc, data: mem_data(model_pc), err: mem_err(model_pc)});
                model_pc = model_pc + 64'd4;
            end
            if (rst_i) begin
                model_pc = RESET_PC;
                buffered = 0;
                sb.delete();
                epoch++;
            end else if (redirect_valid_i) begin
                model_pc = {redirect_pc_i[63:2], 2'b00};
                buffered = 0;
                sb.delete();
                epoch++;
            end else begin
                if (imem_rsp_valid_i && rsp_ep == epoch) buffered++;
                if (inst_valid_o && inst_ready_i) buffered--;
            end
        end
    end

    // Decode-side monitor: pops the scoreboard on every decode handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (started) begin
            if (hold_armed) begin
                chk("hold_valid", 64'(inst_valid_o), 64'd1);
                chk("hold_inst", 64'(inst_o), 64'(hold_inst));
                chk("hold_pc", pc_o, hold_pc);
                chk("hold_err", 64'(fetch_err_o), 64'(hold_err));
            end
            if (rst_i && rst_prev) chk("reset_err", 64'(fetch_err_o), 64'd0);
            if (!rst_i && !redirect_valid_i && inst_valid_o && inst_ready_i) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL inst_unexpected: got pc %h with empty scoreboard at %0t", pc_o, $time);
                end else begin
                    e = sb.pop_front();
                    chk("inst_pc", pc_o, e.pc);
                    chk("inst_data", 64'(inst_o), 64'(e.data));
                    chk("inst_err", 64'(fetch_err_o), 64'(e.err));
                    n_pops++;
                end
            end
            hold_armed = !rst_i && !redirect_valid_i && inst_valid_o && !inst_ready_i;
            hold_inst  = inst_o;
            hold_pc    = pc_o;
            hold_err   = fetch_err_o;
            rst_prev   = rst_i;
        end
    end

    initial begin
        int p0;
        rst_i            = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        inst_ready_i     = 1'b0;
        model_pc = RESET_PC;
        buffered = 0;
        epoch = 0;
        rsp_ep = -1;
        n_pass = 0;
        n_total = 0;
        n_pops = 0;
        started = 1'b0;
        rst_prev = 1'b0;
        hold_armed = 1'b0;

        cycle(1000, 1000, 1000, 0, 1000);
        started = 1'b1;
        repeat (2) cycle(1000, 1000, 1000, 0, 1000);

        // Streaming with a 1-cycle memory; covers the fault at 0x8000_0008.
        p0 = n_pops;
        repeat (40) cycle(1000, 1000, 1000, 0, 0);
        chk("stream_rate", 64'(n_pops - p0 >= 20), 64'd1);

        // Decode stall then resume.
        repeat (10) cycle(1000, 1000, 0, 0, 0);
        repeat (10) cycle(1000, 1000, 1000, 0, 0);

        // Redirect with requests in flight and responses held back.
        repeat (4) cycle(1000, 0, 1000, 0, 0);
        cycle(1000, 0, 1000, 1000, 0, 64'h8000_0102, 1'b1);
        repeat (10) cycle(1000, 1000, 1000, 0, 0);

        // Redirect coincident with a response and a decode pop.
        repeat (6) cycle(1000, 1000, 1000, 0, 0);
        cycle(1000, 1000, 1000, 1000, 0, 64'h8000_0200, 1'b1);
        repeat (10) cycle(1000, 1000, 1000, 0, 0);

        // Randomized traffic with occasional redirects and resets.
        for (int seg = 0; seg < 20; seg++) begin
            int pr, ps, pi;
            pr = $urandom_range(1000, 200);
            ps = $urandom_range(1000, 200);
            pi = $urandom_range(1000, 200);
            repeat (100) cycle(pr, ps, pi, 30, 3);
        end

        // Reset with a full buffer, then restart.
        repeat (6) cycle(1000, 1000, 0, 0, 0);
        cycle(1000, 1000, 0, 0, 1000);
        repeat (20) cycle(1000, 1000, 1000, 0, 0);

        chk("total_pops", 64'(n_pops > 300), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
